sum_latch_uart_tx: RTL and testbench

Parametrised successor to the 4-bit sum-latch UART system. Two operands of DATA_W bits are latched from a shared input bus by active-low save strobes. The block computes A+B or A−B. On a transmit request it serialises the (DATA_W+1)-bit result as one or more 8-bit UART frames, LSB byte first, with optional parity. It sits directly behind the pad wrapper and drives the txd/busy pins.

---
 rtl/sum_latch_uart_tx.sv | 215 +++++++++++++++++++++
 tb/tb_sum_latch_uart_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_latch_uart_tx.sv
// Two-operand add/subtract unit with a UART transmitter that sends the
// (DATA_W+1)-bit result as 8-bit frames, least significant byte first.
module sum_latch_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              mode,
  input  logic              uart_tx_en,
  output logic              uart_txd,
  output logic              uartbusy
);

  localparam int RES_W  = DATA_W + 1;
  localparam int NBYTES = (RES_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);
  localparam logic             PAR_ODD   = (PARITY == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Even-parity bit of one byte (XOR of all bits).
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  logic [2:0]        sa_q, sa_d, sb_q, sb_d, ten_q, ten_d;
  logic [DATA_W-1:0] din1_q, din1_d, din2_q, din2_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]  res_q, res_d, calc_s;
  logic [PAD_W-1:0]  pad_s, sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d, byte_q, byte_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d, busy_q, busy_d;
  logic              fall_a_s, fall_b_s, tx_rise_s, last_s;
  state_t            state_q, state_d;

  // Synchronisers (index 0/1) plus a third flop for edge detection.
  always_comb begin
    sa_d      = {sa_q[1:0], save_a_n};
    sb_d      = {sb_q[1:0], save_b_n};
    ten_d     = {ten_q[1:0], uart_tx_en};
    din1_d    = data_input;
    din2_d    = din1_q;
    fall_a_s  = sa_q[2] & ~sa_q[1];
    fall_b_s  = sb_q[2] & ~sb_q[1];
    tx_rise_s = ten_q[1] & ~ten_q[2];
    if (fall_a_s) begin
      a_d = din2_q;
    end else begin
      a_d = a_q;
    end
    if (fall_b_s) begin
      b_d = din2_q;
    end else begin
      b_d = b_q;
    end
  end

  // Result candidate, zero-padded to a whole number of bytes.
  always_comb begin
    if (mode) begin
      calc_s = {1'b0, a_q} - {1'b0, b_q};
    end else begin
      calc_s = {1'b0, a_q} + {1'b0, b_q};
    end
    pad_s              = '0;
    pad_s[RES_W-1:0]   = calc_s;
  end

  // Frame FSM; each state lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    par_d   = par_q;
    res_d   = res_q;
    last_s  = (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_rise_s) begin
          res_d   = calc_s;
          sh_d    = pad_s;
          par_d   = even_par(pad_s[7:0]);
          byte_d  = 3'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (last_s) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (last_s) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[PAD_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (last_s) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (last_s) begin
          cnt_d = '0;
          if (byte_q == BYTE_LAST) begin
            byte_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            par_d   = even_par(sh_q[7:0]);
            state_d = S_START;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sh_d[0];
      S_PAR:   txd_d = par_d ^ PAR_ODD;
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_q    <= 3'b000;
      sb_q    <= 3'b000;
      ten_q   <= 3'b000;
      din1_q  <= '0;
      din2_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ten_q   <= ten_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

  assign uart_txd = txd_q;
  assign uartbusy = busy_q;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Runs four parameterisations side by side on shared stimulus and compares
// each serial waveform against an ideal frame model.
module tb_sum_latch_uart_tx;

  localparam int CPB = 4;
  localparam int WIN = 100;

  logic        clk = 1'b0;
  logic        reset_n, save_a_n, save_b_n, uart_tx_en, mode;
  logic [11:0] din;
  logic        txd0, txd1, txd2, txd3, busy0, busy1, busy2, busy3;
  logic [3:0]  txd, busy;

  assign txd  = {txd3, txd2, txd1, txd0};
  assign busy = {busy3, busy2, busy1, busy0};

  always #5 clk = ~clk;

  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .PARITY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(din[3:0]), .mode(mode), .uart_tx_en(uart_tx_en),
    .uart_txd(txd0), .uartbusy(busy0));
  sum_latch_uart_tx #(.DATA_W(12), .CLKS_PER_BIT(CPB), .PARITY(0)) u1 (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(din), .mode(mode), .uart_tx_en(uart_tx_en),
    .uart_txd(txd1), .uartbusy(busy1));
  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .PARITY(1)) u2 (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(din[3:0]), .mode(mode), .uart_tx_en(uart_tx_en),
    .uart_txd(txd2), .uartbusy(busy2));
  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB), .PARITY(2)) u3 (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(din[3:0]), .mode(mode), .uart_tx_en(uart_tx_en),
    .uart_txd(txd3), .uartbusy(busy3));

  int errors = 0;
  int checks = 0;
  int dw  [4] = '{4, 12, 4, 4};
  int par [4] = '{0, 0, 1, 2};
  logic [31:0] ma [4];
  logic [31:0] mb [4];
  logic [31:0] snap [4];
  logic txd_log  [4][WIN+1];
  logic busy_log [4][WIN+1];

  function automatic logic [31:0] calc(int d, logic m);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (32'd1 << (dw[d] + 1)) - 32'd1;
    r = m ? (ma[d] - mb[d]) : (ma[d] + mb[d]);
    return r & mask;
  endfunction

  function automatic int frame_len(int d);
    return (par[d] == 0) ? 10 : 11;
  endfunction

  function automatic int busy_len(int d);
    return ((dw[d] + 1 + 7) / 8) * frame_len(d) * CPB;
  endfunction

  function automatic logic exp_txd(int d, int t);
    int b, fr, pos;
    logic [7:0] by;
    if (t < 0 || t >= busy_len(d)) return 1'b1;
    b   = t / CPB;
    fr  = b / frame_len(d);
    pos = b % frame_len(d);
    by  = 8'((snap[d] >> (8 * fr)) & 32'hFF);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return by[pos-1];
    if (pos == 9 && par[d] == 1) return ^by;
    if (pos == 9 && par[d] == 2) return ~^by;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int d, int t);
    return (t >= 0 && t < busy_len(d)) ? 1'b1 : 1'b0;
  endfunction

  task automatic save_op(input logic [11:0] v, input bit do_a, input bit do_b);
    @(negedge clk) din = v;
    @(negedge clk);
    if (do_a) save_a_n = 1'b0;
    if (do_b) save_b_n = 1'b0;
    repeat (3) @(negedge clk);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      if (do_a) ma[d] = 32'(v) & ((32'd1 << dw[d]) - 32'd1);
      if (do_b) mb[d] = 32'(v) & ((32'd1 << dw[d]) - 32'd1);
    end
  endtask

  task automatic launch_and_check(input string name, input bit ovl);
    int bad_t;
    logic bad_v;
    @(negedge clk) uart_tx_en = 1'b1;
    for (int d = 0; d < 4; d++) snap[d] = calc(d, mode);
    @(negedge clk);
    for (int i = 0; i <= WIN; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        txd_log[d][i]  = txd[d];
        busy_log[d][i] = busy[d];
      end
      if (ovl) begin
        case (i - 1)
          5:  mode = ~mode;
          7:  din = 12'h007;
          8:  save_a_n = 1'b0;
          9:  uart_tx_en = 1'b0;
          11: save_a_n = 1'b1;
          14: uart_tx_en = 1'b1;
          18: uart_tx_en = 1'b0;
          default: ;
        endcase
      end
    end
    uart_tx_en = 1'b0;
    if (ovl) begin
      for (int d = 0; d < 4; d++) ma[d] = 32'h7;
    end
    for (int d = 0; d < 4; d++) begin
      bad_t = -2;
      bad_v = 1'b0;
      for (int i = 0; i <= WIN; i++) begin
        if (bad_t == -2 && txd_log[d][i] !== exp_txd(d, i - 1)) begin
          bad_t = i - 1;
          bad_v = txd_log[d][i];
        end
      end
      checks++;
      if (bad_t != -2) begin
        errors++;
        $display("FAIL %s txd dut%0d cycle %0d: got %b expected %b (result %h)",
                 name, d, bad_t, bad_v, exp_txd(d, bad_t), snap[d]);
      end
      bad_t = -2;
      for (int i = 0; i <= WIN; i++) begin
        if (bad_t == -2 && busy_log[d][i] !== exp_busy(d, i - 1)) begin
          bad_t = i - 1;
          bad_v = busy_log[d][i];
        end
      end
      checks++;
      if (bad_t != -2) begin
        errors++;
        $display("FAIL %s busy dut%0d cycle %0d: got %b expected %b",
                 name, d, bad_t, bad_v, exp_busy(d, bad_t));
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; save_a_n = 1'b1; save_b_n = 1'b1;
    uart_tx_en = 1'b0; mode = 1'b0; din = 12'h000;
    for (int d = 0; d < 4; d++) begin
      ma[d] = 32'h0;
      mb[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 4'hF) begin
      errors++;
      $display("FAIL reset txd: got %b expected 1111", txd);
    end
    checks++;
    if (busy !== 4'h0) begin
      errors++;
      $display("FAIL reset busy: got %b expected 0000", busy);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    save_op(12'h005, 1'b1, 1'b1);
    mode = 1'b0;
    @(negedge clk) uart_tx_en = 1'b1;
    repeat (11) @(negedge clk);
    checks++;
    if (busy !== 4'hF) begin
      errors++;
      $display("FAIL midframe inflight busy: got %b expected 1111", busy);
    end
    reset_n = 1'b0;
    uart_tx_en = 1'b0;
    #1;
    checks++;
    if (txd !== 4'hF || busy !== 4'h0) begin
      errors++;
      $display("FAIL midframe async reset: got txd=%b busy=%b expected 1111/0000", txd, busy);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int d = 0; d < 4; d++) begin
      ma[d] = 32'h0;
      mb[d] = 32'h0;
    end
    repeat (6) @(negedge clk);
    launch_and_check("after_reset_zero", 1'b0);
  endtask

  task automatic test_add_carry();
    mode = 1'b0;
    save_op(12'h00F, 1'b1, 1'b0);
    save_op(12'h001, 1'b0, 1'b1);
    launch_and_check("add_carry", 1'b0);
  endtask

  task automatic test_sub_borrow();
    mode = 1'b1;
    save_op(12'h003, 1'b1, 1'b0);
    save_op(12'h005, 1'b0, 1'b1);
    launch_and_check("sub_borrow", 1'b0);
  endtask

  task automatic test_multibyte();
    mode = 1'b0;
    save_op(12'hFFF, 1'b1, 1'b0);
    save_op(12'h001, 1'b0, 1'b1);
    launch_and_check("multibyte", 1'b0);
  endtask

  task automatic test_parity();
    mode = 1'b0;
    save_op(12'h003, 1'b1, 1'b0);
    save_op(12'h000, 1'b0, 1'b1);
    launch_and_check("parity", 1'b0);
  endtask

  task automatic test_overlap();
    mode = 1'b0;
    save_op(12'h009, 1'b1, 1'b0);
    save_op(12'h002, 1'b0, 1'b1);
    launch_and_check("overlap_frame", 1'b1);
    launch_and_check("overlap_next", 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] v;
    for (int n = 0; n < 6; n++) begin
      v = 12'($urandom_range(0, 4095));
      if (n % 3 == 2) begin
        save_op(v, 1'b1, 1'b1);
      end else begin
        save_op(v, 1'b1, 1'b0);
        v = 12'($urandom_range(0, 4095));
        save_op(v, 1'b0, 1'b1);
      end
      mode = 1'($urandom_range(0, 1));
      launch_and_check("random", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_add_carry();
    test_sub_borrow();
    test_multibyte();
    test_parity();
    test_overlap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
